// File: rtl/calc_display_pkg.sv
// rtl/calc_display_pkg.sv - shared types and constants for the calculator display driver
//
// Purpose: conversion FSM state type, segment constants and the BCD-to-segment
// table shared by calc_display_driver and seven_seg_decode.
// Segment encoding is {g,f,e,d,c,b,a}, active-high.
package calc_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } DispState;

    localparam logic [6:0] SEG_BLANK  = 7'b0000000;
    localparam logic [6:0] SEG_MINUS  = 7'b1000000;
    localparam int         NUM_DIGITS = 3;

    // Index 0 is the rightmost entry of the concatenation.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b1101111,   // 9
        7'b1111111,   // 8
        7'b0000111,   // 7
        7'b1111101,   // 6
        7'b1101101,   // 5
        7'b1100110,   // 4
        7'b1001111,   // 3
        7'b1011011,   // 2
        7'b0000110,   // 1
        7'b0111111    // 0
    };

    // Non-decimal codes are never produced by the converter; show them blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        if (digit > 4'd9) begin
            seg = SEG_BLANK;
        end else begin
            seg = SEG_TABLE[digit];
        end
        return seg;
    endfunction

endpackage

// File: rtl/calc_display_driver_seven_seg_decode.sv
// rtl/calc_display_driver_seven_seg_decode.sv - combinational BCD digit to 7-segment decoder
//
// Purpose: turns one BCD digit into segment drive, or all-off when blanked.
// Ports:
//   i_bcd   in  4  BCD digit 0..9
//   i_blank in  1  force all segments off
//   o_seg   out 7  segment drive {g,f,e,d,c,b,a}, active-high
module seven_seg_decode
    import calc_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            o_seg = bcd_to_seg(i_bcd);
        end
    end

endmodule

// File: rtl/calc_display_driver.sv
// rtl/calc_display_driver.sv - binary to BCD converter with multiplexed 7-segment scanner
//
// Purpose: a sequential double-dabble FSM converts each new NumIn value to
// three BCD digits; an independent refresh scanner time-multiplexes them onto
// a 4-position display with leading-zero blanking.
// Optional feature macro: SIGNED_DISPLAY_EN (two's complement input, sign slot).
// Parameters:
//   REFRESH_DIV  cycles each digit position stays enabled (>= 2)
//   NUM_BITS     binary input width (8)
// Ports:
//   clock    in  1   system clock, rising edge
//   Reset    in  1   asynchronous active-high reset
//   NumIn    in  8   value from the accumulator
//   Seg      out 7   registered segment drive {g,f,e,d,c,b,a}
//   DigitEn  out 4   one-hot position enable: units, tens, hundreds, sign
//   Busy     out 1   conversion in progress
//   BcdOut   out 12  committed BCD {hundreds, tens, units}
module calc_display_driver
    import calc_display_pkg::*;
#(
    parameter int REFRESH_DIV = 1024,
    parameter int NUM_BITS    = 8
) (
    input  logic                    clock,
    input  logic                    Reset,
    input  logic [NUM_BITS-1:0]     NumIn,
    output logic [6:0]              Seg,
    output logic [3:0]              DigitEn,
    output logic                    Busy,
    output logic [4*NUM_DIGITS-1:0] BcdOut
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int BIT_W = $clog2(NUM_BITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
`ifdef SIGNED_DISPLAY_EN
    localparam int NUM_SLOTS = 4;
`else
    localparam int NUM_SLOTS = 3;
`endif

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    DispState              r_state;
    logic [NUM_BITS-1:0]   r_shown;
    logic [NUM_BITS-1:0]   r_operand;
    logic [BCD_W-1:0]      r_scratch;
    logic [BCD_W-1:0]      r_bcd;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic                  r_busy;

    logic [NUM_BITS-1:0]   w_mag;
    logic                  w_changed;
    logic [BCD_W-1:0]      w_adj;

`ifdef SIGNED_DISPLAY_EN
    logic                  w_neg;
    logic                  r_neg_shown;
    logic                  r_neg_op;
    logic                  r_neg_bcd;

    // -128 negates to itself, which read as unsigned is the wanted magnitude 128.
    assign w_neg     = NumIn[NUM_BITS-1];
    assign w_mag     = w_neg ? (~NumIn + NUM_BITS'(1)) : NumIn;
    // Sign is part of the identity of the shown value, so -5 after +5 reconverts.
    assign w_changed = (w_mag != r_shown) || (w_neg != r_neg_shown);
`else
    assign w_mag     = NumIn;
    assign w_changed = (w_mag != r_shown);
`endif

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_shown     <= '0;
            r_operand   <= '0;
            r_scratch   <= '0;
            r_bcd       <= '0;
            r_bit_cnt   <= '0;
            r_busy      <= 1'b0;
`ifdef SIGNED_DISPLAY_EN
            r_neg_shown <= 1'b0;
            r_neg_op    <= 1'b0;
            r_neg_bcd   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_changed) begin
                        r_operand   <= w_mag;
                        r_shown     <= w_mag;
                        r_scratch   <= '0;
                        r_bit_cnt   <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= SHIFT;
`ifdef SIGNED_DISPLAY_EN
                        r_neg_shown <= w_neg;
                        r_neg_op    <= w_neg;
`endif
                    end
                end
                SHIFT: begin
                    {r_scratch, r_operand} <= {w_adj, r_operand} << 1;
                    r_bit_cnt              <= r_bit_cnt + BIT_W'(1);
                    if (r_bit_cnt == BIT_LAST) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_bcd     <= r_scratch;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
`ifdef SIGNED_DISPLAY_EN
                    r_neg_bcd <= r_neg_op;
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Refresh scanner
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]     r_scan_cnt;
    logic [NUM_SLOTS-1:0] r_digit_en;
    logic [6:0]           r_seg;

    logic [NUM_SLOTS-1:0] w_next_en;
    logic [3:0]           w_digit;
    logic                 w_blank;
    logic [6:0]           w_seg_dec;
    logic [6:0]           w_seg_next;

    assign w_next_en = {r_digit_en[NUM_SLOTS-2:0], r_digit_en[NUM_SLOTS-1]};

    // Seg is decoded for the position about to be enabled, so it and DigitEn
    // change together and stay stable for the whole slot.
    always_comb begin
        w_digit = r_bcd[3:0];
        w_blank = 1'b0;
        if (w_next_en[1]) begin
            w_digit = r_bcd[7:4];
            w_blank = (r_bcd[11:4] == 8'h00);
        end else if (w_next_en[2]) begin
            w_digit = r_bcd[11:8];
            w_blank = (r_bcd[11:8] == 4'h0);
        end
    end

    seven_seg_decode u_decode (
        .i_bcd   (w_digit),
        .i_blank (w_blank),
        .o_seg   (w_seg_dec)
    );

    always_comb begin
        w_seg_next = w_seg_dec;
`ifdef SIGNED_DISPLAY_EN
        if (w_next_en[3]) begin
            w_seg_next = r_neg_bcd ? SEG_MINUS : SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            r_scan_cnt <= '0;
            r_digit_en <= NUM_SLOTS'(1);
            r_seg      <= SEG_TABLE[0];
        end else if (r_scan_cnt == CNT_LAST) begin
            r_scan_cnt <= '0;
            r_digit_en <= w_next_en;
            r_seg      <= w_seg_next;
        end else begin
            r_scan_cnt <= r_scan_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
`ifdef SIGNED_DISPLAY_EN
    assign DigitEn = r_digit_en;
`else
    assign DigitEn = {1'b0, r_digit_en};
`endif
    assign Seg    = r_seg;
    assign Busy   = r_busy;
    assign BcdOut = r_bcd;

endmodule

// File: tb/tb_calc_display_driver.sv
// tb/tb_calc_display_driver.sv - directed self-checking bench for calc_display_driver
module tb_calc_display_driver;

    logic        clock = 1'b0;
    logic        Reset;
    logic [7:0]  NumIn;
    logic [6:0]  Seg;
    logic [3:0]  DigitEn;
    logic        Busy;
    logic [11:0] BcdOut;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] S_0     = 7'b0111111;
    localparam logic [6:0] S_1     = 7'b0000110;
    localparam logic [6:0] S_2     = 7'b1011011;
    localparam logic [6:0] S_5     = 7'b1101101;
    localparam logic [6:0] S_7     = 7'b0000111;
    localparam logic [6:0] S_OFF   = 7'b0000000;
    localparam logic [6:0] S_MINUS = 7'b1000000;
`ifdef SIGNED_DISPLAY_EN
    localparam int NSLOT = 4;
`else
    localparam int NSLOT = 3;
`endif

    always #5 clock = ~clock;

    calc_display_driver #(
        .REFRESH_DIV (4),
        .NUM_BITS    (8)
    ) dut (
        .clock   (clock),
        .Reset   (Reset),
        .NumIn   (NumIn),
        .Seg     (Seg),
        .DigitEn (DigitEn),
        .Busy    (Busy),
        .BcdOut  (BcdOut)
    );

    task automatic wait_busy(input logic level, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (Busy === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Leaves the bench at the first negedge of a fresh units slot.
    task automatic align_units(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (DigitEn !== 4'b0001) break;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (DigitEn === 4'b0001) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit seen_busy;
        Reset = 1'b1;
        NumIn = 8'd0;
        repeat (3) @(negedge clock);
        checks++; if (BcdOut !== 12'h000) begin failures++; $display("FAIL reset_bcd got=%h exp=000", BcdOut); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (DigitEn !== 4'b0001) begin failures++; $display("FAIL reset_digit_en got=%b exp=0001", DigitEn); end
        checks++; if (Seg !== S_0) begin failures++; $display("FAIL reset_seg got=%b exp=%b", Seg, S_0); end
        Reset = 1'b0;
        seen_busy = 1'b0;
        repeat (15) begin
            @(negedge clock);
            if (Busy !== 1'b0) seen_busy = 1'b1;
        end
        checks++; if (seen_busy) begin failures++; $display("FAIL reset_no_conv got=busy exp=idle"); end
    endtask

    task automatic test_full_scale();
        bit ok;
        int n;
        logic [11:0] exp_bcd;
        logic [6:0]  exp_seg [4];
`ifdef SIGNED_DISPLAY_EN
        exp_bcd = 12'h001;
        exp_seg[0] = S_1; exp_seg[1] = S_OFF; exp_seg[2] = S_OFF; exp_seg[3] = S_MINUS;
`else
        exp_bcd = 12'h255;
        exp_seg[0] = S_5; exp_seg[1] = S_5; exp_seg[2] = S_2; exp_seg[3] = S_OFF;
`endif
        NumIn = 8'd255;
        wait_busy(1'b1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL full_busy_rise got=timeout exp=busy"); end
        n = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (Busy !== 1'b1) break;
            n++;
        end
        checks++; if (n != 9) begin failures++; $display("FAIL full_busy_len got=%0d exp=9", n); end
        checks++; if (BcdOut !== exp_bcd) begin failures++; $display("FAIL full_bcd got=%h exp=%h", BcdOut, exp_bcd); end
        align_units(ok);
        checks++; if (!ok) begin failures++; $display("FAIL full_align got=timeout exp=units_slot"); end
        for (int s = 0; s < NSLOT; s++) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (DigitEn !== (4'b0001 << s) || Seg !== exp_seg[s]) begin
                    failures++;
                    $display("FAIL full_scan slot=%0d cyc=%0d got en=%b seg=%b exp en=%b seg=%b",
                             s, c, DigitEn, Seg, 4'b0001 << s, exp_seg[s]);
                end
                @(negedge clock);
            end
        end
    endtask

    task automatic test_blanking();
        bit ok;
        logic [6:0] exp_seg [4];
        exp_seg[0] = S_7; exp_seg[1] = S_OFF; exp_seg[2] = S_OFF; exp_seg[3] = S_OFF;
        NumIn = 8'd7;
        wait_busy(1'b1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL blank_busy_rise got=timeout exp=busy"); end
        wait_busy(1'b0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL blank_busy_fall got=timeout exp=idle"); end
        checks++; if (BcdOut !== 12'h007) begin failures++; $display("FAIL blank_bcd got=%h exp=007", BcdOut); end
        align_units(ok);
        checks++; if (!ok) begin failures++; $display("FAIL blank_align got=timeout exp=units_slot"); end
        for (int s = 0; s < NSLOT; s++) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (DigitEn !== (4'b0001 << s) || Seg !== exp_seg[s]) begin
                    failures++;
                    $display("FAIL blank_scan slot=%0d cyc=%0d got en=%b seg=%b exp en=%b seg=%b",
                             s, c, DigitEn, Seg, 4'b0001 << s, exp_seg[s]);
                end
                @(negedge clock);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        NumIn = 8'd100;
        wait_busy(1'b1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_busy_rise got=timeout exp=busy"); end
        @(negedge clock);
        @(negedge clock);
        NumIn = 8'd42;
        wait_busy(1'b0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_busy_fall got=timeout exp=idle"); end
        checks++; if (BcdOut !== 12'h100) begin failures++; $display("FAIL b2b_first_bcd got=%h exp=100", BcdOut); end
        @(negedge clock);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL b2b_gap got busy=%b exp=1 after one idle cycle", Busy); end
        n = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (Busy !== 1'b1) break;
            n++;
        end
        checks++; if (n != 9) begin failures++; $display("FAIL b2b_busy_len got=%0d exp=9", n); end
        checks++; if (BcdOut !== 12'h042) begin failures++; $display("FAIL b2b_second_bcd got=%h exp=042", BcdOut); end
    endtask

    task automatic test_toggle_return();
        bit ok;
        bit seen_busy;
        NumIn = 8'd50;
        wait_busy(1'b1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL toggle_busy_rise got=timeout exp=busy"); end
        @(negedge clock);
        NumIn = 8'd60;
        @(negedge clock);
        NumIn = 8'd50;
        wait_busy(1'b0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL toggle_busy_fall got=timeout exp=idle"); end
        checks++; if (BcdOut !== 12'h050) begin failures++; $display("FAIL toggle_bcd got=%h exp=050", BcdOut); end
        seen_busy = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (Busy !== 1'b0) seen_busy = 1'b1;
        end
        checks++; if (seen_busy) begin failures++; $display("FAIL toggle_extra_conv got=busy exp=idle"); end
    endtask

    task automatic test_reset_mid_conversion();
        bit ok;
        logic [11:0] exp_bcd;
`ifdef SIGNED_DISPLAY_EN
        exp_bcd = 12'h056;
`else
        exp_bcd = 12'h200;
`endif
        NumIn = 8'd200;
        wait_busy(1'b1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL midrst_busy_rise got=timeout exp=busy"); end
        @(negedge clock);
        @(negedge clock);
        Reset = 1'b1;
        #1;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", Busy); end
        checks++; if (BcdOut !== 12'h000) begin failures++; $display("FAIL midrst_bcd got=%h exp=000", BcdOut); end
        checks++; if (DigitEn !== 4'b0001 || Seg !== S_0) begin
            failures++; $display("FAIL midrst_scan got en=%b seg=%b exp en=0001 seg=%b", DigitEn, Seg, S_0);
        end
        @(negedge clock);
        Reset = 1'b0;
        wait_busy(1'b1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL midrst_reconv got=timeout exp=busy"); end
        wait_busy(1'b0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL midrst_reconv_done got=timeout exp=idle"); end
        checks++; if (BcdOut !== exp_bcd) begin failures++; $display("FAIL midrst_final_bcd got=%h exp=%h", BcdOut, exp_bcd); end
    endtask

`ifdef SIGNED_DISPLAY_EN
    task automatic test_signed();
        bit ok;
        logic [7:0]  vin  [2];
        logic [11:0] vexp [2];
        vin[0] = 8'hF6; vexp[0] = 12'h010;
        vin[1] = 8'h80; vexp[1] = 12'h128;
        for (int v = 0; v < 2; v++) begin
            NumIn = vin[v];
            wait_busy(1'b1, ok);
            checks++; if (!ok) begin failures++; $display("FAIL signed_busy_rise v=%0d got=timeout exp=busy", v); end
            wait_busy(1'b0, ok);
            checks++; if (!ok) begin failures++; $display("FAIL signed_busy_fall v=%0d got=timeout exp=idle", v); end
            checks++; if (BcdOut !== vexp[v]) begin failures++; $display("FAIL signed_bcd v=%0d got=%h exp=%h", v, BcdOut, vexp[v]); end
            align_units(ok);
            checks++; if (!ok) begin failures++; $display("FAIL signed_align v=%0d got=timeout exp=units_slot", v); end
            repeat (12) @(negedge clock);
            checks++; if (DigitEn !== 4'b1000 || Seg !== S_MINUS) begin
                failures++; $display("FAIL signed_sign_slot v=%0d got en=%b seg=%b exp en=1000 seg=%b", v, DigitEn, Seg, S_MINUS);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_scale();
        test_blanking();
        test_back_to_back();
        test_toggle_return();
        test_reset_mid_conversion();
`ifdef SIGNED_DISPLAY_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_display_driver.md
Name: calc_display_driver

Overview:
Downstream stage of the calculator datapath: consumes the 8-bit accumulator value and drives a multiplexed 4-position 7-segment display. A sequential double-dabble FSM converts each new value to 3 BCD digits. A refresh scanner then time-multiplexes the digits with leading-zero blanking.

Parameters:
REFRESH_DIV, 1024, clock cycles each digit position stays enabled before the scanner advances (>=2)
NUM_BITS, 8, width of the binary input; fixed at 8 for this revision

Ports:
clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
NumIn  input  8  binary value from the accumulator
Seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high
DigitEn  output  4  one-hot digit enable; bit0 = units, bit1 = tens, bit2 = hundreds, bit3 = sign; active-high
Busy  output  1  high while a conversion is in progress
BcdOut  output  12  committed BCD {hundreds, tens, units}; used for observation and test

Behaviour:
- Reset (async, Reset=1):
  - State=IDLE, Shown=0, BcdOut=12'h000, Busy=0.
  - Scan counter=0, DigitEn=4'b0001, Seg=7'b0111111 (units "0").
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - Each edge, compare NumIn (magnitude, see optional feature) against Shown.
  - On mismatch at edge k: latch operand into an 8-bit shift register, Shown<=NumIn, clear the 12-bit BCD scratch, bit counter=0, go to SHIFT, Busy<=1.
- SHIFT, edges k+1..k+8:
  - Each edge, add 3 to every scratch nibble that is >=5, then shift {scratch, operand} left by 1.
  - After the 8th shift, go to COMMIT.
- COMMIT, edge k+9: BcdOut<=scratch, Busy<=0, go to IDLE.
  - Total latency: new value is visible on BcdOut after the 9th edge following capture; Busy is high for exactly 9 cycles.
- NumIn changing during SHIFT or COMMIT is ignored. The conversion in flight completes with the captured operand. The IDLE compare on the next edge then starts a fresh conversion, so the final displayed value always matches the final stable NumIn.
- NumIn toggling and returning to Shown while busy triggers no extra conversion.
- Scanner:
  - Free-running counter 0..REFRESH_DIV-1.
  - On wrap, DigitEn rotates 0001->0010->0100->0001 (3-position ring). With the feature enabled, the ring is 4 positions including 1000.
  - Seg is the registered decode of the enabled position's digit and updates on the same edge as DigitEn.
- Leading-zero blanking:
  - Hundreds digit is blank (Seg=0) if it is 0.
  - Tens digit is blank if both hundreds and tens are 0.
  - Units digit is always shown.
  - A blanked position still takes its scan slot, so brightness stays uniform.
- Scanner is independent of the conversion FSM. BcdOut changes take effect at the next scan slot; no glitch mid-slot beyond one Seg update.
- Reset asserted mid-conversion aborts it immediately. State and outputs return to their reset values.

Optional Feature:
Macro SIGNED_DISPLAY_EN.
- Defined:
  - NumIn is two's complement. Magnitude = bit7 ? (~NumIn+1) : NumIn, with -128 giving magnitude 128.
  - Negative flag is latched with the operand and committed with BcdOut.
  - Scan ring is 4 positions. Sign slot shows 7'b1000000 ("-") when negative, blank otherwise.
- Not defined:
  - Unsigned 0..255 with a 3-position ring; DigitEn[3] is tied 0.
  - No negative flag register exists.

Decomposition:
- Package calc_display_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} DispState
  - localparam SEG_BLANK=7'b0000000
  - localparam SEG_MINUS=7'b1000000
  - localparam NUM_DIGITS=3
  - the 10-entry BCD-to-segment constant table
- One sub-module, seven_seg_decode: combinational, 4-bit BCD plus blank input to 7-bit Seg; instantiated once after the digit mux.

Test Plan (REFRESH_DIV=4):
1. Reset with NumIn=0 -> BcdOut=000, Busy=0, DigitEn=0001, Seg=7'b0111111; no conversion starts after release.
2. NumIn=8'd255 held -> Busy high 9 cycles, then BcdOut=12'h255; scan shows 5,5,2 over 12 cycles in the order units, tens, hundreds.
3. NumIn=8'd7 -> BcdOut=12'h007; the tens and hundreds slots drive Seg=0, the units slot drives 7'b0000111.
4. NumIn 8'd100 then 8'd42 on the 3rd Busy cycle -> BcdOut first 12'h100, then a second conversion gives 12'h042; Busy drops for exactly 1 cycle between conversions.
5. Reset pulsed during SHIFT with NumIn=8'd200 -> BcdOut=000, Busy=0 immediately; after release, a conversion yields 12'h200.
6. SIGNED_DISPLAY_EN with NumIn=8'hF6 -> BcdOut=12'h010, sign slot Seg=7'b1000000. NumIn=8'h80 -> BcdOut=12'h128 with minus shown.
